fifo_nibble_packer: RTL and testbench

Read-side consumer of the circular synchronous 4-bit FIFO. Drains nibbles through the FIFO's `rd_en`/`empty`/`data_out` interface and assembles them, least-significant nibble first, into wide words. Presents the words downstream on a valid/ready handshake. A `flush` input forces out a partially filled word.

---
 rtl/fifo_nibble_packer_pkg.sv | 11 +
 rtl/fifo_nibble_packer.sv | 102 ++++++++++
 tb/tb_fifo_nibble_packer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_nibble_packer_pkg.sv
// Values shared by the 4-bit FIFO and its nibble packer: default widths and
// the packer's two-state controller encoding.
package fifo_nibble_packer_pkg;

    localparam int PKR_DATA_W  = 4;
    localparam int PKR_NIBBLES = 4;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

endpackage

// File: rtl/fifo_nibble_packer.sv
// Drains nibbles from the FIFO read port and packs them LS-slot first into
// wide words, offered downstream on valid/ready; flush emits a partial word.
module fifo_nibble_packer
    import fifo_nibble_packer_pkg::*;
#(
    parameter int DATA_W  = PKR_DATA_W,
    parameter int NIBBLES = PKR_NIBBLES,
    parameter int OUT_W   = DATA_W * NIBBLES,
    parameter int LEN_W   = $clog2(NIBBLES) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    input  logic              flush,
    output logic [OUT_W-1:0]  out_data,
    output logic [LEN_W-1:0]  out_len,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [LEN_W-1:0] FULL_CNT = LEN_W'(NIBBLES);
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

    logic [0:0]       state;
    logic [LEN_W-1:0] issued;
    logic [LEN_W-1:0] captured;
    logic             rd_pend;
    logic             flush_pend;

    logic [LEN_W-1:0] cap_next;
    logic             word_done;
    logic             idle;

    assign cap_next  = captured + ONE;
    assign word_done = rd_pend && (cap_next == FULL_CNT);
    assign idle      = (issued == captured);

    // Qualified by reset so no read is requested while the shared reset is held.
    assign fifo_rd_en = reset && (state == FILL) && !fifo_empty &&
                        (issued < FULL_CNT) && !flush_pend;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= FILL;
            issued     <= '0;
            captured   <= '0;
            rd_pend    <= 1'b0;
            flush_pend <= 1'b0;
            out_data   <= '0;
            out_len    <= '0;
            out_valid  <= 1'b0;
        end else begin
            rd_pend <= fifo_rd_en;
            if (fifo_rd_en)
                issued <= issued + ONE;

            if (rd_pend) begin
                captured <= cap_next;
                for (int k = 0; k < NIBBLES; k++)
                    if (captured == LEN_W'(k))
                        out_data[DATA_W*k +: DATA_W] <= fifo_data;
            end

            case (state)
                FILL: begin
                    if (word_done) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_len   <= FULL_CNT;
                    end else if (flush_pend && idle) begin
                        // Nothing in flight: emit what we have, or just drop the request.
                        if (captured != '0) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_len   <= captured;
                        end else begin
                            flush_pend <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        state      <= FILL;
                        out_valid  <= 1'b0;
                        issued     <= '0;
                        captured   <= '0;
                        out_data   <= '0;
                        flush_pend <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase

            // A new request wins over any clear in the same cycle.
            if (flush)
                flush_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Bench for fifo_nibble_packer: behavioural FIFO, queue-based word model and
// a negedge monitor that scores every accepted word.
module tb_fifo_nibble_packer;
    import fifo_nibble_packer_pkg::*;

    localparam int DW = 4;
    localparam int NB = 4;
    localparam int OW = DW * NB;
    localparam int LW = $clog2(NB) + 1;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          flush = 1'b0;
    logic [OW-1:0] out_data;
    logic [LW-1:0] out_len;
    logic          out_valid;
    logic          out_ready = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    fifo_nibble_packer #(.DATA_W(DW), .NIBBLES(NB)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .flush(flush), .out_data(out_data),
        .out_len(out_len), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // FIFO stand-in: one-cycle read latency, emptied by the shared reset.
    logic [DW-1:0] mem [0:DEPTH-1];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (wp == rp);
    always @(posedge clk) begin
        if (!reset) rp <= wp;
        else if (fifo_rd_en) begin
            fifo_data <= mem[rp % DEPTH];
            rp <= rp + 1;
        end
    end

    // Reference: nibbles since the last word boundary, and words still owed.
    typedef struct { logic [OW-1:0] data; logic [LW-1:0] len; } word_t;
    word_t expq[$];
    logic [DW-1:0] cur[$];

    function automatic void model_emit();
        word_t w;
        w.data = '0;
        for (int i = 0; i < cur.size(); i++)
            w.data = w.data + (OW'(cur[i]) << (DW * i));
        w.len = LW'(cur.size());
        expq.push_back(w);
        cur.delete();
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_nib(input logic [DW-1:0] v);
        mem[wp % DEPTH] = v;
        wp++;
        cur.push_back(v);
        if (cur.size() == NB) model_emit();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        if (cur.size() > 0) model_emit();
        step();
        flush = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        bit done = 0;
        for (int i = 0; i < bound && !done; i++) begin
            if (expq.size() == 0 && !out_valid) done = 1;
            else step();
        end
        chk("drain_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_valid(input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            if (out_valid) seen = 1;
            else step();
        end
        chk("valid_timeout", {31'd0, seen}, 32'd1);
    endtask

    // Monitor: scores transfers, handshake stability and read legality.
    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic [OW-1:0] pd = '0;
    word_t         mw;
    always @(negedge clk) begin
        if (!reset) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {16'd0, out_data}, {16'd0, pd});
            end
            if (fifo_empty) chk("rd_while_empty", {31'd0, fifo_rd_en}, 32'd0);
            if (out_valid) chk("rd_in_hold", {31'd0, fifo_rd_en}, 32'd0);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h len %0d expected none", out_data, out_len);
                end else begin
                    mw = expq.pop_front();
                    chk("word_data", {16'd0, out_data}, {16'd0, mw.data});
                    chk("word_len", {29'd0, out_len}, {29'd0, mw.len});
                end
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
        end
    end

    initial begin
        // Reset held two cycles with the FIFO non-empty.
        step();
        mem[wp % DEPTH] = 4'h9;
        wp++;
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        chk("rst_len", {29'd0, out_len}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        step();
        reset = 1'b1;

        // Full word latency: reads in cycles 0-3, valid in cycle 5.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push_nib(DW'(i));
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            chk("lat_rd_en", {31'd0, fifo_rd_en}, {31'd0, (c <= 3)});
            chk("lat_valid", {31'd0, out_valid}, {31'd0, (c == 5)});
            step();
        end
        wait_idle(20);

        // Backpressure across two words.
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_nib(DW'(i));
        wait_valid(20);
        chk("bp_first", {16'd0, out_data}, 32'h4321);
        repeat (6) step();
        out_ready = 1'b1;
        wait_idle(40);

        // Underflow gap in the middle of a word.
        push_nib(4'h1);
        push_nib(4'h2);
        repeat (5) step();
        push_nib(4'h3);
        push_nib(4'h4);
        wait_idle(40);

        // Flush of a two-nibble partial, then a flush with nothing captured.
        push_nib(4'hA);
        push_nib(4'hB);
        step();
        step();
        do_flush();
        wait_valid(20);
        chk("flush_data", {16'd0, out_data}, 32'h00BA);
        chk("flush_len", {29'd0, out_len}, 32'd2);
        wait_idle(20);
        do_flush();
        repeat (4) step();
        @(negedge clk);
        chk("empty_flush", {31'd0, out_valid}, 32'd0);
        step();

        // Reset with two nibbles captured and one in flight.
        push_nib(4'h1);
        push_nib(4'h2);
        push_nib(4'h3);
        repeat (3) step();
        reset = 1'b0;
        expq.delete();
        cur.delete();
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {16'd0, out_data}, 32'd0);
        chk("mid_rst_len", {29'd0, out_len}, 32'd0);
        chk("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        step();
        for (int i = 5; i <= 8; i++) push_nib(DW'(i));
        wait_valid(20);
        chk("post_rst_data", {16'd0, out_data}, 32'h8765);
        wait_idle(20);

        // Random pushes, backpressure and flushes on an empty FIFO.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 9);
            out_ready = ($urandom_range(0, 3) != 0);
            if (r < 5) begin
                push_nib(DW'($urandom_range(0, 15)));
                step();
            end else if (r == 5 && fifo_empty) begin
                do_flush();
            end else begin
                step();
            end
        end
        out_ready = 1'b1;
        wait_idle(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
